// File: rtl/bpred_table_ctrl.sv
// Branch-prediction table controller: sweeps the table to INITVALUE, serves
// fetch lookups on port B and applies queued saturating-counter updates.
module bpred_table_ctrl #(
   parameter int PCWIDTH        = 32,
   parameter int TABLEDEPTH     = 4096,
   parameter int LOG2TABLEDEPTH = 12,
   parameter int TABLEWIDTH     = 2,
   parameter int INITVALUE      = 1,
   parameter int FIFODEPTH      = 4,
   parameter int LOG2FIFODEPTH  = 2
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      flush,
   output logic                      busy,
   input  logic                      predict,
   input  logic [PCWIDTH-1:0]        pc_predict,
   output logic                      prediction,
   input  logic                      result_rdy,
   input  logic                      result,
   input  logic [PCWIDTH-1:0]        pc_result,
   output logic                      result_full,
   output logic                      overflow,
   output logic                      tbl_wren,
   output logic [LOG2TABLEDEPTH-1:0] tbl_waddr,
   output logic [TABLEWIDTH-1:0]     tbl_wdata,
   output logic                      tbl_rden,
   output logic [LOG2TABLEDEPTH-1:0] tbl_raddr,
   input  logic [TABLEWIDTH-1:0]     tbl_q
);

   localparam logic [0:0] SWEEP = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;

   localparam logic [1:0] U_IDLE  = 2'd0;
   localparam logic [1:0] U_READ  = 2'd1;
   localparam logic [1:0] U_WRITE = 2'd2;

   localparam logic [LOG2TABLEDEPTH-1:0] LAST_ADDR = LOG2TABLEDEPTH'(TABLEDEPTH - 1);
   localparam logic [LOG2FIFODEPTH:0]    FIFO_FULL = (LOG2FIFODEPTH + 1)'(FIFODEPTH);
   localparam logic [LOG2FIFODEPTH:0]    CNT_ONE   = (LOG2FIFODEPTH + 1)'(1);

   logic [0:0]                state;
   logic [1:0]                ustate;
   logic [LOG2TABLEDEPTH-1:0] sweep_addr;
   logic [LOG2TABLEDEPTH-1:0] fifo_idx [FIFODEPTH];
   logic                      fifo_res [FIFODEPTH];
   logic [LOG2FIFODEPTH-1:0]  wr_ptr;
   logic [LOG2FIFODEPTH-1:0]  rd_ptr;
   logic [LOG2FIFODEPTH:0]    count;
   logic                      hold;
   logic                      last_pred;

   logic                      run;
   logic                      push;
   logic                      pop;
   logic                      upd_rd;
   logic [LOG2TABLEDEPTH-1:0] pidx;
   logic [LOG2TABLEDEPTH-1:0] ridx;
   logic [LOG2TABLEDEPTH-1:0] head_idx;
   logic                      head_res;
   logic [TABLEWIDTH-1:0]     upd_data;
   logic                      unused_pc;

   assign run      = (state == RUN);
   assign pidx     = pc_predict[LOG2TABLEDEPTH+1:2];
   assign ridx     = pc_result[LOG2TABLEDEPTH+1:2];
   assign head_idx = fifo_idx[rd_ptr];
   assign head_res = fifo_res[rd_ptr];
   assign unused_pc = ^{pc_predict[PCWIDTH-1:LOG2TABLEDEPTH+2], pc_predict[1:0],
                        pc_result[PCWIDTH-1:LOG2TABLEDEPTH+2], pc_result[1:0]};

   assign result_full = (count == FIFO_FULL);
   assign pop    = run && !flush && (ustate == U_WRITE);
   assign push   = run && !flush && result_rdy && (!result_full || pop);
   assign upd_rd = run && !flush && !predict && (ustate == U_READ);

   always_comb begin
      upd_data = tbl_q;
      if (head_res) begin
         if (tbl_q != '1) upd_data = tbl_q + TABLEWIDTH'(1);
      end else begin
         if (tbl_q != '0) upd_data = tbl_q - TABLEWIDTH'(1);
      end
   end

   // resetn gates the write so nothing reaches the RAM while reset is held
   assign tbl_wren   = resetn && (!run || pop);
   assign tbl_waddr  = run ? head_idx : sweep_addr;
   assign tbl_wdata  = run ? upd_data : TABLEWIDTH'(INITVALUE);
   assign tbl_rden   = run && (predict || upd_rd);
   assign tbl_raddr  = predict ? pidx : head_idx;
   assign busy       = !run;
   assign prediction = run && (last_pred ? tbl_q[TABLEWIDTH-1] : hold);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_idx[wr_ptr] <= ridx;
         fifo_res[wr_ptr] <= result;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= SWEEP;
         ustate     <= U_IDLE;
         sweep_addr <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         hold       <= 1'b0;
         last_pred  <= 1'b0;
      end else begin
         if (tbl_rden) last_pred <= predict;
         if (run && last_pred) hold <= tbl_q[TABLEWIDTH-1];

         if (!run || flush) begin
            ustate <= U_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (flush) begin
               state      <= SWEEP;
               sweep_addr <= '0;
               overflow   <= 1'b0;
            end else begin
               sweep_addr <= sweep_addr + 1'b1;
               if (sweep_addr == LAST_ADDR) state <= RUN;
            end
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + CNT_ONE;
               2'b01:   count <= count - CNT_ONE;
               default: count <= count;
            endcase
            if (result_rdy && !push) overflow <= 1'b1;

            case (ustate)
               U_IDLE:  if (count != '0) ustate <= U_READ;
               U_READ:  if (!predict) ustate <= U_WRITE;
               // chain straight into the next read to sustain one update per two cycles
               U_WRITE: ustate <= (count > CNT_ONE || push) ? U_READ : U_IDLE;
               default: ustate <= U_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bpred_table_ctrl.sv
// Directed bench for bpred_table_ctrl on a 16-entry table with a behavioural
// dual-port RAM (registered read, old data on read-during-write).
module tb_bpred_table_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        busy;
   logic        predict;
   logic [31:0] pc_predict;
   logic        prediction;
   logic        result_rdy;
   logic        result;
   logic [31:0] pc_result;
   logic        result_full;
   logic        overflow;
   logic        tbl_wren;
   logic [3:0]  tbl_waddr;
   logic [1:0]  tbl_wdata;
   logic        tbl_rden;
   logic [3:0]  tbl_raddr;
   logic [1:0]  tbl_q;

   logic [1:0]  mem [16];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tbl_wren) mem[tbl_waddr] <= tbl_wdata;
      if (tbl_rden) tbl_q <= mem[tbl_raddr];
   end

   bpred_table_ctrl #(
      .PCWIDTH(32), .TABLEDEPTH(16), .LOG2TABLEDEPTH(4), .TABLEWIDTH(2),
      .INITVALUE(1), .FIFODEPTH(4), .LOG2FIFODEPTH(2)
   ) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .busy(busy),
      .predict(predict), .pc_predict(pc_predict), .prediction(prediction),
      .result_rdy(result_rdy), .result(result), .pc_result(pc_result),
      .result_full(result_full), .overflow(overflow),
      .tbl_wren(tbl_wren), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
      .tbl_rden(tbl_rden), .tbl_raddr(tbl_raddr), .tbl_q(tbl_q)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_result(input logic [31:0] pc, input logic r);
      @(negedge clk);
      result_rdy = 1'b1;
      pc_result  = pc;
      result     = r;
      @(negedge clk);
      result_rdy = 1'b0;
      #1;
   endtask

   // Waits (bounded) for the next table write and checks its latency and contents.
   task automatic wait_write(input string tag, input logic [3:0] a, input logic [1:0] d,
                             input int exp_k);
      int k = 0;
      while (tbl_wren !== 1'b1 && k < 8) begin
         @(negedge clk);
         #1;
         k++;
      end
      check({tag, "_lat"}, k, exp_k);
      check({tag, "_wren"}, tbl_wren, 1);
      check({tag, "_waddr"}, tbl_waddr, a);
      check({tag, "_wdata"}, tbl_wdata, d);
      @(negedge clk);
      #1;
   endtask

   task automatic count_quiet(input string tag, input int cycles);
      int nw = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         #1;
         if (tbl_wren !== 1'b0) nw++;
      end
      check(tag, nw, 0);
   endtask

   initial begin
      int ones;
      resetn = 1'b0; flush = 1'b0; predict = 1'b0; pc_predict = '0;
      result_rdy = 1'b0; result = 1'b0; pc_result = '0;

      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", busy, 1);
      check("rst_pred", prediction, 0);
      check("rst_wren", tbl_wren, 0);
      check("rst_rden", tbl_rden, 0);
      check("rst_full", result_full, 0);
      check("rst_ovf", overflow, 0);

      // post-reset sweep, with a result offered mid-sweep
      @(negedge clk);
      resetn = 1'b1;
      #1;
      for (int i = 0; i < 16; i++) begin
         check("sweep_wren", tbl_wren, 1);
         check("sweep_waddr", tbl_waddr, i);
         check("sweep_wdata", tbl_wdata, 1);
         check("sweep_busy", busy, 1);
         check("sweep_rden", tbl_rden, 0);
         @(negedge clk);
         result_rdy = (i == 4);
         pc_result  = 32'h44;
         result     = 1'b1;
         #1;
      end
      check("sweep_done_busy", busy, 0);
      check("sweep_done_wren", tbl_wren, 0);
      check("sweep_full", result_full, 0);
      check("sweep_ovf", overflow, 0);
      ones = 0;
      for (int a = 0; a < 16; a++) if (mem[a] === 2'd1) ones++;
      check("sweep_mem", ones, 16);
      count_quiet("sweep_ignore", 4);

      // saturation on index 0 (PC 0x40), first update checked cycle by cycle
      @(negedge clk);
      result_rdy = 1'b1; pc_result = 32'h40; result = 1'b1;
      #1;
      @(negedge clk);
      result_rdy = 1'b0;
      #1;
      check("lat1_wren", tbl_wren, 0);
      check("lat1_rden", tbl_rden, 0);
      @(negedge clk);
      #1;
      check("lat2_rden", tbl_rden, 1);
      check("lat2_raddr", tbl_raddr, 0);
      check("lat2_wren", tbl_wren, 0);
      @(negedge clk);
      #1;
      check("lat3_wren", tbl_wren, 1);
      check("lat3_waddr", tbl_waddr, 0);
      check("lat3_wdata", tbl_wdata, 2);
      @(negedge clk);
      #1;
      send_result(32'h40, 1'b1);
      wait_write("sat_t2", 4'd0, 2'd3, 2);
      send_result(32'h40, 1'b1);
      wait_write("sat_t3", 4'd0, 2'd3, 2);

      @(negedge clk);
      predict = 1'b1; pc_predict = 32'h40;
      #1;
      check("pred_rden", tbl_rden, 1);
      check("pred_raddr", tbl_raddr, 0);
      @(negedge clk);
      predict = 1'b0;
      #1;
      check("pred_taken", prediction, 1);

      send_result(32'h40, 1'b0);
      wait_write("sat_n1", 4'd0, 2'd2, 2);
      send_result(32'h40, 1'b0);
      wait_write("sat_n2", 4'd0, 2'd1, 2);
      send_result(32'h40, 1'b0);
      wait_write("sat_n3", 4'd0, 2'd0, 2);
      send_result(32'h40, 1'b0);
      wait_write("sat_n4", 4'd0, 2'd0, 2);
      check("pred_hold_after_upd", prediction, 1);
      @(negedge clk);
      predict = 1'b1; pc_predict = 32'h40;
      @(negedge clk);
      predict = 1'b0;
      #1;
      check("pred_not_taken", prediction, 0);

      // same-index burst on index 5 (value 1)
      @(negedge clk);
      result_rdy = 1'b1; pc_result = 32'h14; result = 1'b1;
      @(negedge clk);
      @(negedge clk);
      result_rdy = 1'b0;
      #1;
      wait_write("burst1", 4'd5, 2'd2, 1);
      wait_write("burst2", 4'd5, 2'd3, 1);

      // arbitration: predict index 6 (value 1) held while an update to index 5 waits
      @(negedge clk);
      predict = 1'b1; pc_predict = 32'h18;
      result_rdy = 1'b1; pc_result = 32'h14; result = 1'b1;
      #1;
      check("arb_rden0", tbl_rden, 1);
      check("arb_raddr0", tbl_raddr, 6);
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         result_rdy = 1'b0;
         #1;
         check("arb_rden", tbl_rden, 1);
         check("arb_raddr", tbl_raddr, 6);
         check("arb_wren", tbl_wren, 0);
         check("arb_pred", prediction, 0);
      end
      @(negedge clk);
      predict = 1'b0;
      #1;
      check("arb_upd_rden", tbl_rden, 1);
      check("arb_upd_raddr", tbl_raddr, 5);
      check("arb_upd_pred", prediction, 0);
      @(negedge clk);
      #1;
      check("arb_wr_wren", tbl_wren, 1);
      check("arb_wr_waddr", tbl_waddr, 5);
      check("arb_wr_wdata", tbl_wdata, 3);
      check("arb_wr_pred_hold", prediction, 0);
      @(negedge clk);
      #1;

      // overflow: five results while predict starves the updater
      @(negedge clk);
      predict = 1'b1; pc_predict = 32'h18;
      for (int i = 0; i < 5; i++) begin
         result_rdy = 1'b1; pc_result = 32'h20 + 32'(4 * i); result = 1'b1;
         #1;
         check("ovf_full", result_full, (i == 4));
         check("ovf_flag", overflow, 0);
         @(negedge clk);
      end
      result_rdy = 1'b0;
      #1;
      check("ovf_set", overflow, 1);
      check("ovf_full_hold", result_full, 1);
      @(negedge clk);
      predict = 1'b0;
      #1;
      check("drain_first_wren", tbl_wren, 0);
      wait_write("drain0", 4'd8, 2'd2, 1);
      wait_write("drain1", 4'd9, 2'd2, 1);
      wait_write("drain2", 4'd10, 2'd2, 1);
      wait_write("drain3", 4'd11, 2'd2, 1);
      count_quiet("drain_no_fifth", 3);
      check("drain_ovf_sticky", overflow, 1);
      check("drain_full", result_full, 0);

      // flush while an update sits in U_READ
      send_result(32'h34, 1'b1);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_nowrite", tbl_wren, 0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_busy", busy, 1);
      check("flush_ovf_clr", overflow, 0);
      check("flush_full", result_full, 0);
      for (int i = 0; i < 8; i++) begin
         check("fsweep_wren", tbl_wren, 1);
         check("fsweep_waddr", tbl_waddr, i);
         @(negedge clk);
         flush = (i == 6);
         #1;
      end
      for (int j = 0; j < 16; j++) begin
         check("rsweep_busy", busy, 1);
         check("rsweep_waddr", tbl_waddr, j);
         check("rsweep_wdata", tbl_wdata, 1);
         @(negedge clk);
         #1;
      end
      check("rsweep_done", busy, 0);
      count_quiet("flush_queue_empty", 4);
      check("flush_ovf_final", overflow, 0);

      // asynchronous reset in the middle of a sweep
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check("areset_wren", tbl_wren, 0);
      check("areset_busy", busy, 1);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check("areset_restart_wren", tbl_wren, 1);
      check("areset_restart_addr", tbl_waddr, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
